axi_lite_cmd_master: RTL

//  AXI4-Lite initiator. Turns a simple command stream (valid/ready) into single AXI4-Lite

---
 rtl/axi_lite_cmd_master.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_cmd_master.sv
// AXI4-Lite initiator: one command in, one single-beat AXI-Lite read or write out, one response back.
// Optional transaction/error counters are enabled with `define AXI_LITE_CMD_MASTER_STATS_EN.
module axi_lite_cmd_master #(
    parameter int         C_M_AXI_ADDR_WIDTH = 32,
    parameter int         C_M_AXI_DATA_WIDTH = 32,
    parameter logic [2:0] C_M_AXI_PROT       = 3'b000
) (
    input  logic                            M_AXI_ACLK,
    input  logic                            M_AXI_ARESETN,
    input  logic                            cmd_valid,
    output logic                            cmd_ready,
    input  logic                            cmd_write,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [C_M_AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                            rsp_valid,
    input  logic                            rsp_ready,
    output logic                            rsp_write,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]                      rsp_resp,
    output logic                            busy,
`ifdef AXI_LITE_CMD_MASTER_STATS_EN
    input  logic                            stat_clear,
    output logic [31:0]                     stat_wr_count,
    output logic [31:0]                     stat_rd_count,
    output logic [31:0]                     stat_err_count,
`endif
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
    output logic [2:0]                      M_AXI_ARPROT,
    output logic                            M_AXI_ARVALID,
    input  logic                            M_AXI_ARREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
    input  logic [1:0]                      M_AXI_RRESP,
    input  logic                            M_AXI_RVALID,
    output logic                            M_AXI_RREADY
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_WR_AW_W = 3'd1;
    localparam logic [2:0] ST_WR_B    = 3'd2;
    localparam logic [2:0] ST_RD_AR   = 3'd3;
    localparam logic [2:0] ST_RD_R    = 3'd4;
    localparam logic [2:0] ST_RSP     = 3'd5;

    function automatic logic [C_M_AXI_ADDR_WIDTH-1:0] word_align(input logic [C_M_AXI_ADDR_WIDTH-1:0] a);
        return a & ~{{(C_M_AXI_ADDR_WIDTH-2){1'b0}}, 2'b11};
    endfunction

    logic [2:0]                      state_r;
    logic [2:0]                      state_nxt_s;
    logic [C_M_AXI_ADDR_WIDTH-1:0]   addr_r;
    logic [C_M_AXI_DATA_WIDTH-1:0]   wdata_r;
    logic [C_M_AXI_DATA_WIDTH/8-1:0] wstrb_r;
    logic                            awvalid_r, wvalid_r, arvalid_r, bready_r, rready_r;
    logic                            rsp_valid_r, rsp_write_r, busy_r;
    logic [C_M_AXI_DATA_WIDTH-1:0]   rsp_rdata_r;
    logic [1:0]                      rsp_resp_r;
    logic                            accept_s, aw_open_s, w_open_s, b_hs_s, r_hs_s;

    // Handshake qualifiers; AW/W each stay open only until their own READY is seen
    always_comb begin
        accept_s  = (state_r == ST_IDLE) && cmd_valid;
        aw_open_s = awvalid_r && !M_AXI_AWREADY;
        w_open_s  = wvalid_r && !M_AXI_WREADY;
        b_hs_s    = (state_r == ST_WR_B) && M_AXI_BVALID;
        r_hs_s    = (state_r == ST_RD_R) && M_AXI_RVALID;
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) state_nxt_s = cmd_write ? ST_WR_AW_W : ST_RD_AR;
                else           state_nxt_s = ST_IDLE;
            end
            ST_WR_AW_W: begin
                if (!aw_open_s && !w_open_s) state_nxt_s = ST_WR_B;
                else                         state_nxt_s = ST_WR_AW_W;
            end
            ST_WR_B: begin
                if (M_AXI_BVALID) state_nxt_s = ST_RSP;
                else              state_nxt_s = ST_WR_B;
            end
            ST_RD_AR: begin
                if (M_AXI_ARREADY) state_nxt_s = ST_RD_R;
                else               state_nxt_s = ST_RD_AR;
            end
            ST_RD_R: begin
                if (M_AXI_RVALID) state_nxt_s = ST_RSP;
                else              state_nxt_s = ST_RD_R;
            end
            ST_RSP: begin
                if (rsp_ready) state_nxt_s = ST_IDLE;
                else           state_nxt_s = ST_RSP;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State, captured command, registered handshake outputs and response
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            state_r     <= ST_IDLE;
            addr_r      <= '0;
            wdata_r     <= '0;
            wstrb_r     <= '0;
            awvalid_r   <= 1'b0;
            wvalid_r    <= 1'b0;
            arvalid_r   <= 1'b0;
            bready_r    <= 1'b0;
            rready_r    <= 1'b0;
            rsp_valid_r <= 1'b0;
            rsp_write_r <= 1'b0;
            busy_r      <= 1'b0;
            rsp_rdata_r <= '0;
            rsp_resp_r  <= 2'b00;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                addr_r      <= word_align(cmd_addr);
                rsp_write_r <= cmd_write;
                if (cmd_write) begin
                    wdata_r <= cmd_wdata;
                    wstrb_r <= cmd_wstrb;
                end
            end
            awvalid_r   <= (accept_s && cmd_write) || aw_open_s;
            wvalid_r    <= (accept_s && cmd_write) || w_open_s;
            arvalid_r   <= (state_nxt_s == ST_RD_AR);
            bready_r    <= (state_nxt_s == ST_WR_B);
            rready_r    <= (state_nxt_s == ST_RD_R);
            rsp_valid_r <= (state_nxt_s == ST_RSP);
            busy_r      <= (state_nxt_s != ST_IDLE);
            if (b_hs_s) begin
                rsp_rdata_r <= '0;
                rsp_resp_r  <= M_AXI_BRESP;
            end else if (r_hs_s) begin
                rsp_rdata_r <= M_AXI_RDATA;
                rsp_resp_r  <= M_AXI_RRESP;
            end
        end
    end

`ifdef AXI_LITE_CMD_MASTER_STATS_EN
    // Transaction and error counters; clear takes priority over any increment
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            stat_wr_count  <= 32'd0;
            stat_rd_count  <= 32'd0;
            stat_err_count <= 32'd0;
        end else if (stat_clear) begin
            stat_wr_count  <= 32'd0;
            stat_rd_count  <= 32'd0;
            stat_err_count <= 32'd0;
        end else begin
            if (b_hs_s) stat_wr_count <= stat_wr_count + 32'd1;
            if (r_hs_s) stat_rd_count <= stat_rd_count + 32'd1;
            if ((b_hs_s && (M_AXI_BRESP != 2'b00)) || (r_hs_s && (M_AXI_RRESP != 2'b00)))
                stat_err_count <= stat_err_count + 32'd1;
        end
    end
`endif

    assign cmd_ready     = (state_r == ST_IDLE);
    assign busy          = busy_r;
    assign rsp_valid     = rsp_valid_r;
    assign rsp_write     = rsp_write_r;
    assign rsp_rdata     = rsp_rdata_r;
    assign rsp_resp      = rsp_resp_r;
    assign M_AXI_AWADDR  = addr_r;
    assign M_AXI_ARADDR  = addr_r;
    assign M_AXI_AWPROT  = C_M_AXI_PROT;
    assign M_AXI_ARPROT  = C_M_AXI_PROT;
    assign M_AXI_AWVALID = awvalid_r;
    assign M_AXI_WVALID  = wvalid_r;
    assign M_AXI_WDATA   = wdata_r;
    assign M_AXI_WSTRB   = wstrb_r;
    assign M_AXI_ARVALID = arvalid_r;
    assign M_AXI_BREADY  = bready_r;
    assign M_AXI_RREADY  = rready_r;

endmodule
